// File: rtl/fp16_pkg.sv
// Shared types and constants for the FP16 add back end (normalize, round, pack).
package fp16_pkg;

  localparam int FP16_BIAS    = 15;
  localparam int FP16_EXP_MAX = 31;
  localparam int FP16_EXP_W   = 5;
  localparam int FP16_FRAC_W  = 10;
  localparam int RAW_MAN_W    = 15;
  localparam int WORK_EXP_W   = 6;

  localparam int FLAG_OVERFLOW  = 2;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_INEXACT   = 0;

  typedef struct packed {
    logic                   sign;
    logic [FP16_EXP_W-1:0]  exp;
    logic [FP16_FRAC_W-1:0] frac;
  } fp16_t;

  // Working copy of the raw sum; the exponent has one spare bit so overflow is visible
  typedef struct packed {
    logic                  sign;
    logic [WORK_EXP_W-1:0] exp;
    logic [RAW_MAN_W-1:0]  man;
  } raw_sum_t;

  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} norm_state_e;

endpackage

// File: rtl/fp16_lzc.sv
// Leading-zero count over the hidden+fraction bits of the working mantissa.
// An all-zero input reports 11 so the caller can keep pulling up G/R/S bits.
module fp16_lzc (
  input  logic [10:0] bits,
  output logic [3:0]  count
);

  always_comb begin
    count = 4'd11;
    for (int i = 0; i < 11; i++) begin
      if (bits[i]) count = 4'(10 - i);
    end
  end

endmodule

// File: rtl/fp16_norm_round.sv
// Normalize / round-to-nearest-even / pack stage of the FP16 adder.
// Define FP16_FTZ_EN to flush subnormal results to signed zero.
module fp16_norm_round
  import fp16_pkg::*;
#(
  parameter int SHIFT_STEP = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [4:0]  in_exp,
  input  logic [14:0] in_man,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_result,
  output logic [2:0]  out_flags
);

  norm_state_e state_q, state_d;
  raw_sum_t    work_q, work_d;
  fp16_t       result_q, result_d;
  logic [2:0]  flags_q, flags_d;

  logic [3:0]  lz;
  logic [5:0]  shamt;
  logic        round_up, inexact, tiny;
  logic [11:0] rounded;
  logic [10:0] round_man;
  logic [5:0]  round_exp;

  fp16_lzc u_lzc (
    .bits  (work_q.man[13:3]),
    .count (lz)
  );

  // Left shift per NORM cycle is bounded by the step size, the zeros left and the exponent floor
  always_comb begin
    shamt = 6'(SHIFT_STEP);
    if ({2'b00, lz} < shamt) shamt = {2'b00, lz};
    if ((work_q.exp - 6'd1) < shamt) shamt = work_q.exp - 6'd1;
  end

  always_comb begin
    round_up  = work_q.man[2] & (work_q.man[1] | work_q.man[0] | work_q.man[3]);
    rounded   = {1'b0, work_q.man[13:3]} + {11'b0, round_up};
    round_man = rounded[11] ? rounded[11:1] : rounded[10:0];
    round_exp = work_q.exp + {5'b0, rounded[11]};
    inexact   = |work_q.man[2:0];
    tiny      = ~work_q.man[13];
  end

  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    result_d = result_q;
    flags_d  = flags_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d.sign = in_sign;
          work_d.exp  = (in_exp == 5'd0) ? 6'd1 : {1'b0, in_exp};
          work_d.man  = in_man;
          state_d     = NORM;
        end
      end
      NORM: begin
        if (work_q.man == '0) begin
          work_d.sign = 1'b0;
          work_d.exp  = 6'd1;
          state_d     = ROUND;
        end else if (work_q.man[14]) begin
          work_d.man = {1'b0, work_q.man[14:2], work_q.man[1] | work_q.man[0]};
          work_d.exp = work_q.exp + 6'd1;
          state_d    = ROUND;
        end else if (!work_q.man[13] && (work_q.exp > 6'd1)) begin
          work_d.man = work_q.man << shamt;
          work_d.exp = work_q.exp - shamt;
          if (work_d.man[13] || (work_d.exp == 6'd1)) state_d = ROUND;
        end else begin
          state_d = ROUND;
        end
      end
      ROUND: begin
        flags_d = '0;
        if (round_exp >= 6'(FP16_EXP_MAX)) begin
          result_d.sign = work_q.sign;
          result_d.exp  = 5'h1F;
          result_d.frac = '0;
          flags_d[FLAG_OVERFLOW] = 1'b1;
          flags_d[FLAG_INEXACT]  = 1'b1;
        end else if (!round_man[10]) begin
`ifdef FP16_FTZ_EN
          result_d.sign = work_q.sign;
          result_d.exp  = '0;
          result_d.frac = '0;
          flags_d[FLAG_UNDERFLOW] = |work_q.man;
          flags_d[FLAG_INEXACT]   = |work_q.man;
`else
          result_d.sign = work_q.sign;
          result_d.exp  = '0;
          result_d.frac = round_man[9:0];
          flags_d[FLAG_UNDERFLOW] = inexact;
          flags_d[FLAG_INEXACT]   = inexact;
`endif
        end else begin
          // A tiny value that rounds up to the smallest normal still reports underflow
          result_d.sign = work_q.sign;
          result_d.exp  = round_exp[4:0];
          result_d.frac = round_man[9:0];
          flags_d[FLAG_UNDERFLOW] = tiny & inexact;
          flags_d[FLAG_INEXACT]   = inexact;
        end
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      work_q   <= '0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign out_result = result_q;
  assign out_flags  = flags_q;

endmodule

// File: tb/tb_fp16_norm_round.sv
// Randomized self-checking bench for fp16_norm_round against an exact-value rounding model.
module tb_fp16_norm_round;

  localparam int STEP = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_sign = 1'b0;
  logic [4:0]  in_exp = '0;
  logic [14:0] in_man = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_result;
  logic [2:0]  out_flags;

  int n_compared = 0;
  int n_mismatched = 0;

  fp16_norm_round #(.SHIFT_STEP(STEP)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sign    (in_sign),
    .in_exp     (in_exp),
    .in_man     (in_man),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flags  (out_flags)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Exact value of the raw sum in units of 2^-27, rounded RNE onto the binary16 grid
  task automatic refModel(input logic s, input logic [4:0] e, input logic [14:0] m,
                          output logic [15:0] res, output logic [2:0] flg, output int lat);
    longint q, rem, half, val;
    int     ee, u, msb, ef, top, sc, nc;
    logic   ix, un;
    ee  = (e == 5'd0) ? 1 : int'(e);
    q   = longint'(m) << (ee - 1);
    res = '0;
    flg = '0;
    if (q != 0) begin
      msb = 0;
      for (int i = 0; i < 48; i++) if (q[i]) msb = i;
      u    = (msb - 10 > 3) ? msb - 10 : 3;
      half = longint'(1) << (u - 1);
      rem  = q % (longint'(1) << u);
      val  = q >> u;
      if (rem > half || (rem == half && val[0])) val = val + 1;
      val = val << u;
      ix  = (rem != 0);
      un  = ix && (q < (longint'(1) << 13));
      if (val < (longint'(1) << 13)) begin
`ifdef FP16_FTZ_EN
        res = {s, 15'h0};
        flg = 3'b011;
`else
        res = {s, 5'h0, 10'(val >> 3)};
        flg = {1'b0, un, ix};
`endif
      end else begin
        msb = 0;
        for (int i = 0; i < 48; i++) if (val[i]) msb = i;
        ef = msb - 12;
        if (ef >= 31) begin
          res = {s, 5'h1F, 10'h0};
          flg = 3'b101;
        end else begin
          res = {s, 5'(ef), 10'(val >> (msb - 10))};
          flg = {1'b0, un, ix};
        end
      end
    end
    if (m == 15'h0 || m[14] || m[13]) begin
      nc = 1;
    end else begin
      top = 0;
      for (int i = 0; i < 14; i++) if (m[i]) top = i;
      sc = 13 - top;
      if (sc > ee - 1) sc = ee - 1;
      nc = (sc == 0) ? 1 : (sc + STEP - 1) / STEP;
    end
    lat = 2 + nc;
  endtask

  task automatic applyStimulus(input logic s, input logic [4:0] e, input logic [14:0] m, input int hold);
    logic [15:0] exp_res;
    logic [2:0]  exp_flg;
    int          exp_lat, lat, waited;
    refModel(s, e, m, exp_res, exp_flg, exp_lat);
    waited = 0;
    while (!in_ready && waited < 100) begin
      @(posedge clk); #1;
      waited++;
    end
    checkOutput("in_ready_before_accept", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_sign  = s;
    in_exp   = e;
    in_man   = m;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_man   = 15'($urandom);
    in_exp   = 5'($urandom);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput("out_valid", 32'(out_valid), 32'd1);
    checkOutput("result", 32'(out_result), 32'(exp_res));
    checkOutput("flags", 32'(out_flags), 32'(exp_flg));
    checkOutput("latency", 32'(lat), 32'(exp_lat));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      checkOutput("hold_valid", 32'(out_valid), 32'd1);
      checkOutput("hold_result", 32'(out_result), 32'(exp_res));
      checkOutput("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput("release_valid", 32'(out_valid), 32'd0);
  endtask

  task automatic applyDirected(input logic s, input logic [4:0] e, input logic [14:0] m,
                               input logic [15:0] res, input logic [2:0] flg, input string tag);
    applyStimulus(s, e, m, 0);
    checkOutput({tag, "_result"}, 32'(out_result), 32'(res));
    checkOutput({tag, "_flags"}, 32'(out_flags), 32'(flg));
  endtask

  initial begin
    logic        s;
    logic [4:0]  e;
    logic [14:0] m;
    int          waited;

    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset_result", 32'(out_result), 32'd0);
    checkOutput("reset_flags", 32'(out_flags), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    applyDirected(1'b0, 5'd15, 15'h4000, 16'h4000, 3'b000, "one_plus_one");
    applyDirected(1'b0, 5'd15, 15'h0008, 16'h1400, 3'b000, "cancel");
    applyDirected(1'b0, 5'd15, 15'h200C, 16'h3C02, 3'b001, "round_up");
    applyDirected(1'b0, 5'd15, 15'h2004, 16'h3C00, 3'b001, "tie_even");
    applyDirected(1'b1, 5'd30, 15'h4000, 16'hFC00, 3'b101, "overflow");
    applyDirected(1'b1, 5'd15, 15'h0000, 16'h0000, 3'b000, "zero");
`ifdef FP16_FTZ_EN
    applyDirected(1'b0, 5'd1, 15'h0802, 16'h0000, 3'b011, "subnormal");
`else
    applyDirected(1'b0, 5'd1, 15'h0802, 16'h0100, 3'b011, "subnormal");
`endif
    applyDirected(1'b0, 5'd0, 15'h2000, 16'h0400, 3'b000, "exp0_as_1");
    applyDirected(1'b0, 5'd30, 15'h3FFC, 16'h7C00, 3'b101, "round_overflow");
    applyStimulus(1'b0, 5'd31, 15'h0001, 0);
    applyStimulus(1'b0, 5'd15, 15'h2000, 10);

    // Abort a long normalization with reset and make sure nothing leaks out
    waited = 0;
    while (!in_ready && waited < 100) begin
      @(posedge clk); #1;
      waited++;
    end
    in_valid = 1'b1;
    in_sign  = 1'b1;
    in_exp   = 5'd20;
    in_man   = 15'h0001;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("midnorm_busy", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_out_valid", 32'(out_valid), 32'd0);
    checkOutput("abort_in_ready", 32'(in_ready), 32'd1);
    checkOutput("abort_result", 32'(out_result), 32'd0);
    checkOutput("abort_flags", 32'(out_flags), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      checkOutput("no_partial_output", 32'(out_valid), 32'd0);
    end

    for (int n = 0; n < 400; n++) begin
      s = 1'($urandom_range(0, 1));
      e = 5'($urandom_range(0, 31));
      case ($urandom_range(0, 3))
        0: m = 15'($urandom);
        1: m = 15'($urandom) >> $urandom_range(0, 14);
        2: m = {2'b01, 13'($urandom)};
        default: begin
          e = 5'($urandom_range(29, 31));
          m = {2'b01, 10'h3FF, 3'($urandom)};
        end
      endcase
      applyStimulus(s, e, m, $urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed no finish expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
